// File: rtl/key_event_scheduler.sv
// key_event_scheduler
//   Collects key events from the PS/2 decoder and the USB keycode register,
//   queues them in a small FIFO and releases at most one keycode per video
//   frame, on the falling edge of VGA vertical sync, to the ball logic.
//
// Optional feature macro: KEY_EVENT_SCHEDULER_USB_EN
//   defined   : USB source, USB pending latch and round-robin arbitration.
//   undefined : usb_code ignored, PS/2 only, frame_src tied to 0.
//
// Ports
//   Clk          : system clock
//   Reset        : synchronous, active-high reset
//   ps2_code     : current PS/2 keycode
//   ps2_press    : high while a PS/2 key is held
//   usb_code     : USB keycode register, 0 = no key
//   vs           : VGA vertical sync (active low), synchronous to Clk
//   frame_key    : keycode for the current frame, 0 when none
//   frame_valid  : frame_key holds a real key
//   frame_strobe : one-cycle pulse on every frame edge
//   frame_src    : source of frame_key, 0 = PS/2, 1 = USB
//   fifo_count   : current FIFO occupancy
//   overflow     : sticky, an event was lost; cleared only by Reset
module key_event_scheduler #(
   parameter int DEPTH = 4,
   parameter int KW    = 8
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [KW-1:0]            ps2_code,
   input  logic                     ps2_press,
   input  logic [KW-1:0]            usb_code,
   input  logic                     vs,
   output logic [KW-1:0]            frame_key,
   output logic                     frame_valid,
   output logic                     frame_strobe,
   output logic                     frame_src,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic              ps2_press_q;
   logic [KW-1:0]     ps2_code_q;
   logic              vs_q;
   logic              ps2_pend_r;
   logic [KW-1:0]     ps2_pend_code_r;
   logic [KW:0]       mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic              overflow_r;
   logic [KW-1:0]     frame_key_r;
   logic              frame_valid_r;
   logic              frame_strobe_r;

   logic              ps2_evt_s;
   logic              full_s;
   logic              frame_edge_s;
   logic              pop_s;
   logic              push_s;
   logic              grant_ps2_s;
   logic              repeat_s;
   logic              lost_s;
   logic [KW:0]       push_data_s;
   logic [KW:0]       head_s;

`ifdef KEY_EVENT_SCHEDULER_USB_EN
   logic [KW-1:0]     usb_code_q;
   logic              usb_pend_r;
   logic [KW-1:0]     usb_pend_code_r;
   logic              rr_r;
   logic              frame_src_r;
   logic              usb_evt_s;
   logic              grant_usb_s;
`else
   logic              unused_s;
   assign unused_s = ^{usb_code, head_s[KW]};
`endif

   assign full_s       = (count_r == FULL_CNT);
   assign frame_edge_s = vs_q && !vs;
   assign pop_s        = frame_edge_s && (count_r != {CW{1'b0}});
   assign head_s       = mem_r[rd_ptr_r];

   // Event detection, arbitration, overflow detection and repeat check.
   always_comb begin
      ps2_evt_s   = ps2_press && (!ps2_press_q || (ps2_code != ps2_code_q));
      grant_ps2_s = 1'b0;
`ifdef KEY_EVENT_SCHEDULER_USB_EN
      usb_evt_s   = (usb_code != usb_code_q) && (usb_code != {KW{1'b0}});
      grant_usb_s = 1'b0;
      if (full_s) begin
         grant_ps2_s = 1'b0;
         grant_usb_s = 1'b0;
      end else if (ps2_pend_r && usb_pend_r) begin
         // contention: rr names the source that wins this time
         grant_usb_s = rr_r;
         grant_ps2_s = !rr_r;
      end else begin
         grant_ps2_s = ps2_pend_r;
         grant_usb_s = usb_pend_r;
      end
      push_s      = grant_ps2_s || grant_usb_s;
      push_data_s = grant_usb_s ? {1'b1, usb_pend_code_r} : {1'b0, ps2_pend_code_r};
      // a latch being drained on this edge is not lost when reloaded
      lost_s      = (ps2_evt_s && ps2_pend_r && !grant_ps2_s) ||
                    (usb_evt_s && usb_pend_r && !grant_usb_s);
      if (frame_src_r) begin
         repeat_s = frame_valid_r && (usb_code == frame_key_r);
      end else begin
         repeat_s = frame_valid_r && ps2_press && (ps2_code == frame_key_r);
      end
`else
      if (full_s) begin
         grant_ps2_s = 1'b0;
      end else begin
         grant_ps2_s = ps2_pend_r;
      end
      push_s      = grant_ps2_s;
      push_data_s = {1'b0, ps2_pend_code_r};
      lost_s      = ps2_evt_s && ps2_pend_r && !grant_ps2_s;
      repeat_s    = frame_valid_r && ps2_press && (ps2_code == frame_key_r);
`endif
   end

   // Previous-value registers for edge and change detection.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ps2_press_q <= 1'b0;
         ps2_code_q  <= {KW{1'b0}};
         vs_q        <= 1'b1;
`ifdef KEY_EVENT_SCHEDULER_USB_EN
         usb_code_q  <= {KW{1'b0}};
`endif
      end else begin
         ps2_press_q <= ps2_press;
         ps2_code_q  <= ps2_code;
         vs_q        <= vs;
`ifdef KEY_EVENT_SCHEDULER_USB_EN
         usb_code_q  <= usb_code;
`endif
      end
   end

   // Pending latches, round-robin pointer and sticky overflow.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ps2_pend_r      <= 1'b0;
         ps2_pend_code_r <= {KW{1'b0}};
         overflow_r      <= 1'b0;
`ifdef KEY_EVENT_SCHEDULER_USB_EN
         usb_pend_r      <= 1'b0;
         usb_pend_code_r <= {KW{1'b0}};
         rr_r            <= 1'b0;
`endif
      end else begin
         if (ps2_evt_s) begin
            ps2_pend_r      <= 1'b1;
            ps2_pend_code_r <= ps2_code;
         end else if (grant_ps2_s) begin
            ps2_pend_r      <= 1'b0;
         end
         if (lost_s) begin
            overflow_r <= 1'b1;
         end
`ifdef KEY_EVENT_SCHEDULER_USB_EN
         if (usb_evt_s) begin
            usb_pend_r      <= 1'b1;
            usb_pend_code_r <= usb_code;
         end else if (grant_usb_s) begin
            usb_pend_r      <= 1'b0;
         end
         // rr only moves when both sources competed for the push
         if (grant_ps2_s && usb_pend_r) begin
            rr_r <= 1'b1;
         end else if (grant_usb_s && ps2_pend_r) begin
            rr_r <= 1'b0;
         end
`endif
      end
   end

   // FIFO storage; validity is tracked by the pointers, so no reset needed.
   always_ff @(posedge Clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= push_data_s;
      end
   end

   // FIFO pointers (wrap modulo DEPTH) and occupancy.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Frame scheduler: pop, repeat or release on every vsync falling edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_key_r    <= {KW{1'b0}};
         frame_valid_r  <= 1'b0;
         frame_strobe_r <= 1'b0;
`ifdef KEY_EVENT_SCHEDULER_USB_EN
         frame_src_r    <= 1'b0;
`endif
      end else begin
         frame_strobe_r <= frame_edge_s;
         if (pop_s) begin
            frame_key_r   <= head_s[KW-1:0];
            frame_valid_r <= 1'b1;
`ifdef KEY_EVENT_SCHEDULER_USB_EN
            frame_src_r   <= head_s[KW];
`endif
         end else if (frame_edge_s && !repeat_s) begin
            frame_key_r   <= {KW{1'b0}};
            frame_valid_r <= 1'b0;
         end
      end
   end

   assign frame_key    = frame_key_r;
   assign frame_valid  = frame_valid_r;
   assign frame_strobe = frame_strobe_r;
`ifdef KEY_EVENT_SCHEDULER_USB_EN
   assign frame_src    = frame_src_r;
`else
   assign frame_src    = 1'b0;
`endif
   assign fifo_count   = count_r;
   assign overflow     = overflow_r;

endmodule

// File: tb/tb_key_event_scheduler.sv
module tb_key_event_scheduler;
   localparam int DEPTH = 4;
   localparam int KW    = 8;
`ifdef KEY_EVENT_SCHEDULER_USB_EN
   localparam bit USB_EN = 1'b1;
`else
   localparam bit USB_EN = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset;
   logic [7:0] ps2_code;
   logic       ps2_press;
   logic [7:0] usb_code;
   logic       vs;
   logic [7:0] frame_key;
   logic       frame_valid;
   logic       frame_strobe;
   logic       frame_src;
   logic [2:0] fifo_count;
   logic       overflow;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [8:0] m_q[$];
   bit         m_pend[2];
   logic [7:0] m_pcode[2];
   bit         m_rr;
   logic [7:0] m_key;
   bit         m_valid, m_strobe, m_src, m_ovf;
   logic       m_prev_press, m_prev_vs;
   logic [7:0] m_prev_ps2, m_prev_usb;

   logic [14:0] dut_vec;
   assign dut_vec = {frame_key, frame_valid, frame_strobe, frame_src, fifo_count, overflow};

   always #5 Clk = ~Clk;

   key_event_scheduler #(.DEPTH(DEPTH), .KW(KW)) dut (
      .Clk(Clk), .Reset(Reset), .ps2_code(ps2_code), .ps2_press(ps2_press),
      .usb_code(usb_code), .vs(vs), .frame_key(frame_key), .frame_valid(frame_valid),
      .frame_strobe(frame_strobe), .frame_src(frame_src), .fifo_count(fifo_count),
      .overflow(overflow)
   );

   function automatic logic [14:0] exp_vec();
      return {m_key, m_valid, m_strobe, m_src, 3'(m_q.size()), m_ovf};
   endfunction

   // One clock of the behavioural model, using the inputs sampled at this edge.
   task automatic model_step();
      bit ev0, ev1, edge_f;
      int g;
      logic [8:0] h;
      if (Reset) begin
         m_q.delete();
         m_pend[0] = 0; m_pend[1] = 0;
         m_pcode[0] = 8'h00; m_pcode[1] = 8'h00;
         m_rr = 0; m_key = 8'h00; m_valid = 0; m_strobe = 0; m_src = 0; m_ovf = 0;
         m_prev_press = 1'b0; m_prev_vs = 1'b1; m_prev_ps2 = 8'h00; m_prev_usb = 8'h00;
         return;
      end
      ev0 = ps2_press && (!m_prev_press || ps2_code != m_prev_ps2);
      ev1 = USB_EN && (usb_code != m_prev_usb) && (usb_code != 8'h00);
      edge_f = m_prev_vs && !vs;
      g = -1;
      if (m_q.size() < DEPTH) begin
         if (m_pend[0] && m_pend[1]) begin
            g = m_rr ? 1 : 0;
            m_rr = (g == 0);
         end else if (m_pend[0]) g = 0;
         else if (m_pend[1]) g = 1;
      end
      m_strobe = edge_f;
      if (edge_f) begin
         if (m_q.size() > 0) begin
            h = m_q.pop_front();
            m_key = h[7:0]; m_src = h[8]; m_valid = 1;
         end else if (m_valid && (m_src ? (usb_code == m_key) : (ps2_press && ps2_code == m_key))) begin
            m_valid = 1;
         end else begin
            m_key = 8'h00; m_valid = 0;
         end
      end
      if (g >= 0) begin
         m_q.push_back({g[0], m_pcode[g]});
         m_pend[g] = 0;
      end
      if (ev0) begin
         if (m_pend[0]) m_ovf = 1;
         m_pend[0] = 1; m_pcode[0] = ps2_code;
      end
      if (ev1) begin
         if (m_pend[1]) m_ovf = 1;
         m_pend[1] = 1; m_pcode[1] = usb_code;
      end
      m_prev_press = ps2_press; m_prev_vs = vs;
      m_prev_ps2 = ps2_code; m_prev_usb = usb_code;
   endtask

   task automatic tick();
      @(posedge Clk);
      model_step();
      @(negedge Clk);
   endtask

   task automatic apply_reset();
      Reset = 1'b1; ps2_press = 1'b0; ps2_code = 8'h00; usb_code = 8'h00; vs = 1'b1;
      tick();
      Reset = 1'b0;
   endtask

   task automatic frame_edge();
      vs = 1'b0;
      tick();
      vs = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      tick();
      tests++;
      if (dut_vec !== 15'h0000) begin
         fails++; $display("FAIL reset_values got=%h exp=%h", dut_vec, 15'h0000);
      end
      tests++;
      if (dut_vec !== exp_vec()) begin
         fails++; $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_single_ps2();
      apply_reset();
      ps2_code = 8'h1A; ps2_press = 1'b1;
      tick(); tick();
      tests++;
      if (fifo_count !== 3'd1) begin
         fails++; $display("FAIL single_count got=%0d exp=1", fifo_count);
      end
      frame_edge();
      tests++;
      if ({frame_key, frame_valid, frame_src, frame_strobe} !== {8'h1A, 1'b1, 1'b0, 1'b1}) begin
         fails++; $display("FAIL single_frame got key=%h v=%b src=%b stb=%b exp key=1a v=1 src=0 stb=1",
                           frame_key, frame_valid, frame_src, frame_strobe);
      end
      tick();
      tests++;
      if ({frame_key, frame_strobe} !== {8'h1A, 1'b0}) begin
         fails++; $display("FAIL single_strobe_once got key=%h stb=%b exp key=1a stb=0", frame_key, frame_strobe);
      end
      ps2_press = 1'b0;
      tick();
      frame_edge();
      tests++;
      if ({frame_key, frame_valid, frame_strobe} !== {8'h00, 1'b0, 1'b1}) begin
         fails++; $display("FAIL single_release got key=%h v=%b stb=%b exp key=00 v=0 stb=1",
                           frame_key, frame_valid, frame_strobe);
      end
      tick();
   endtask

   task automatic test_full_fifo();
      logic [7:0] exp_keys [5];
      exp_keys[0] = 8'h10; exp_keys[1] = 8'h11; exp_keys[2] = 8'h12;
      exp_keys[3] = 8'h13; exp_keys[4] = 8'h15;
      apply_reset();
      ps2_press = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ps2_code = 8'(8'h10 + i);
         tick();
      end
      tests++;
      if ({fifo_count, overflow} !== {3'd4, 1'b0}) begin
         fails++; $display("FAIL full_count got cnt=%0d ovf=%b exp cnt=4 ovf=0", fifo_count, overflow);
      end
      ps2_code = 8'h15;
      tick();
      tests++;
      if ({fifo_count, overflow} !== {3'd4, 1'b1}) begin
         fails++; $display("FAIL full_overflow got cnt=%0d ovf=%b exp cnt=4 ovf=1", fifo_count, overflow);
      end
      for (int i = 0; i < 5; i++) begin
         frame_edge();
         tests++;
         if ({frame_key, frame_valid} !== {exp_keys[i], 1'b1}) begin
            fails++; $display("FAIL full_pop%0d got key=%h v=%b exp key=%h v=1", i, frame_key, frame_valid, exp_keys[i]);
         end
         tests++;
         if (dut_vec !== exp_vec()) begin
            fails++; $display("FAIL full_model%0d got=%h exp=%h", i, dut_vec, exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_auto_repeat();
      apply_reset();
      if (USB_EN) usb_code = 8'h1A;
      else begin ps2_code = 8'h1A; ps2_press = 1'b1; end
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         frame_edge();
         tests++;
         if ({frame_key, frame_valid, fifo_count, overflow} !== {8'h1A, 1'b1, 3'd0, 1'b0}) begin
            fails++; $display("FAIL repeat%0d got key=%h v=%b cnt=%0d ovf=%b exp key=1a v=1 cnt=0 ovf=0",
                              k, frame_key, frame_valid, fifo_count, overflow);
         end
         tick(); tick();
      end
      usb_code = 8'h00; ps2_press = 1'b0;
      tick();
   endtask

   task automatic test_push_pop();
      apply_reset();
      ps2_press = 1'b1; ps2_code = 8'h20;
      tick(); tick();
      ps2_code = 8'h21;
      tick();
      frame_edge();
      tests++;
      if ({fifo_count, frame_key, frame_strobe} !== {3'd1, 8'h20, 1'b1}) begin
         fails++; $display("FAIL pushpop_same got cnt=%0d key=%h stb=%b exp cnt=1 key=20 stb=1",
                           fifo_count, frame_key, frame_strobe);
      end
      tick();
      frame_edge();
      tests++;
      if ({fifo_count, frame_key} !== {3'd0, 8'h21}) begin
         fails++; $display("FAIL pushpop_next got cnt=%0d key=%h exp cnt=0 key=21", fifo_count, frame_key);
      end
      tick();
   endtask

   task automatic test_simultaneous();
`ifdef KEY_EVENT_SCHEDULER_USB_EN
      logic [8:0] exp_e [4];
      exp_e[0] = 9'h004; exp_e[1] = 9'h107; exp_e[2] = 9'h108; exp_e[3] = 9'h005;
      apply_reset();
      ps2_press = 1'b1; ps2_code = 8'h04; usb_code = 8'h07;
      tick(); tick();
      tests++;
      if (fifo_count !== 3'd1) begin
         fails++; $display("FAIL simul_first got cnt=%0d exp=1", fifo_count);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         frame_edge();
         tests++;
         if ({frame_src, frame_key} !== exp_e[i]) begin
            fails++; $display("FAIL simul_a%0d got=%h exp=%h", i, {frame_src, frame_key}, exp_e[i]);
         end
         tick();
      end
      ps2_code = 8'h05; usb_code = 8'h08;
      tick(); tick(); tick();
      for (int i = 2; i < 4; i++) begin
         frame_edge();
         tests++;
         if ({frame_src, frame_key} !== exp_e[i]) begin
            fails++; $display("FAIL simul_b%0d got=%h exp=%h", i, {frame_src, frame_key}, exp_e[i]);
         end
         tick();
      end
`endif
   endtask

   task automatic test_reset_mid();
      apply_reset();
      ps2_press = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ps2_code = 8'(8'h30 + i);
         tick();
      end
      frame_edge();
      tests++;
      if ({fifo_count, overflow} !== {3'd3, 1'b1}) begin
         fails++; $display("FAIL midreset_pre got cnt=%0d ovf=%b exp cnt=3 ovf=1", fifo_count, overflow);
      end
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      tests++;
      if (dut_vec !== 15'h0000) begin
         fails++; $display("FAIL midreset_vals got=%h exp=%h", dut_vec, 15'h0000);
      end
      ps2_press = 1'b0;
      tick(); tick();
      frame_edge();
      tests++;
      if ({frame_key, frame_valid, fifo_count, overflow} !== {8'h00, 1'b0, 3'd0, 1'b0}) begin
         fails++; $display("FAIL midreset_stale got key=%h v=%b cnt=%0d ovf=%b exp key=00 v=0 cnt=0 ovf=0",
                           frame_key, frame_valid, fifo_count, overflow);
      end
      tick();
   endtask

   task automatic test_random();
      int vs_cnt;
      vs_cnt = 4;
      apply_reset();
      for (int n = 0; n < 3000; n++) begin
         Reset = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 3) == 0) ps2_press = ~ps2_press;
         if ($urandom_range(0, 2) == 0) ps2_code = 8'($urandom_range(1, 4));
         if ($urandom_range(0, 3) == 0) usb_code = 8'($urandom_range(0, 3));
         if (vs_cnt == 0) begin
            vs = 1'b0; vs_cnt = $urandom_range(2, 12);
         end else begin
            vs = (vs_cnt == 1 && $urandom_range(0, 1) == 0) ? vs : 1'b1;
            vs_cnt--;
         end
         tick();
         tests++;
         if (dut_vec !== exp_vec()) begin
            fails++; $display("FAIL random_cycle%0d got=%h exp=%h", n, dut_vec, exp_vec());
         end
      end
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; ps2_press = 1'b0; ps2_code = 8'h00; usb_code = 8'h00; vs = 1'b1;
      test_reset();
      test_single_ps2();
      test_full_fifo();
      test_auto_repeat();
      test_push_pop();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
